// File: rtl/display_pkg.sv
// Shared types and constants for the display scanner and its BCD converter.
package display_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_COMMIT  = 2'd2;

  typedef logic [3:0] bcd_digit_t;

  // Widest supported display; narrower tops slice the low DIGITS bits.
  localparam logic [7:0] AN_OFF = 8'hFF;

  // Largest value representable on `digits` decimal digits (10^digits - 1).
  function automatic logic [31:0] digit_limit(input int digits);
    logic [31:0] lim;
    lim = 32'd1;
    for (int i = 0; i < digits; i++) lim = lim * 32'd10;
    return lim - 32'd1;
  endfunction

endpackage

// File: rtl/bcd_converter.sv
// Sequential double-dabble: WIDTH shift-and-add-3 iterations after start,
// done flags the cycle whose edge performs the final iteration.
module bcd_converter
  import display_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]    shift;
  logic [CW-1:0]       remaining;
  logic                active;
  logic [4*DIGITS-1:0] adj;

  // Digits above DIGITS are dropped; such values are replaced by all-nines upstream.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign done = active && (remaining == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift     <= '0;
      remaining <= '0;
      active    <= 1'b0;
      bcd       <= '0;
    end else if (start) begin
      shift     <= value;
      remaining <= CW'(WIDTH - 1);
      active    <= 1'b1;
      bcd       <= '0;
    end else if (active) begin
      bcd   <= {adj[4*DIGITS-2:0], shift[WIDTH-1]};
      shift <= shift << 1;
      if (remaining == '0) active <= 1'b0;
      else                 remaining <= remaining - 1'b1;
    end
  end

endmodule

// File: rtl/display_scanner.sv
// Loads a binary value, converts it to BCD and scans the digits onto num/an.
//   state      | meaning
//   ST_IDLE    | waiting for load; display shows committed digits
//   ST_CONVERT | bcd_converter iterating WIDTH cycles
//   ST_COMMIT  | write display register and ovf, back to idle
module display_scanner
  import display_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int WIDTH    = 14,
  parameter int SCAN_DIV = 50000,
  parameter int LZB      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  value,
  input  logic              load,
  output logic              busy,
  output logic              ovf,
  output logic [3:0]        num,
  output logic [DIGITS-1:0] an
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [31:0]         LIMIT     = digit_limit(DIGITS);
  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'd9}};
  localparam logic [DIGITS-1:0]   EN_LSB    = DIGITS'(1);
  localparam logic [DIGITS-1:0]   AN_ALL    = AN_OFF[DIGITS-1:0];

  logic [1:0]          state;
  logic                ovf_pend;
  logic [4*DIGITS-1:0] disp;
  logic [4*DIGITS-1:0] conv_bcd;
  logic                conv_done;
  logic                accept;
  logic [31:0]         value_ext;
  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       idx_d;
  logic                blank_d;
  logic                started;
  logic [DIGITS-1:0]   blank;
  logic                zero_above;
  bcd_digit_t          digit_arr [DIGITS];

  assign accept = (state == ST_IDLE) && load;
  assign busy   = (state != ST_IDLE);

  always_comb begin
    value_ext = '0;
    value_ext[WIDTH-1:0] = value;
  end

  bcd_converter #(.DIGITS(DIGITS), .WIDTH(WIDTH)) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept),
    .value (value),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ovf_pend <= 1'b0;
      ovf      <= 1'b0;
      disp     <= '0;
    end else begin
      case (state)
        ST_IDLE: if (load) begin
          state    <= ST_CONVERT;
          ovf_pend <= (value_ext > LIMIT);
        end
        ST_CONVERT: if (conv_done) state <= ST_COMMIT;
        ST_COMMIT: begin
          disp  <= ovf_pend ? ALL_NINES : conv_bcd;
          ovf   <= ovf_pend;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Digit i (i > 0) blanks when it and every more significant digit are zero.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (disp[4*i +: 4] == 4'd0);
      blank[i]   = (LZB != 0) && zero_above;
    end
    for (int i = 0; i < DIGITS; i++) digit_arr[i] = disp[4*i +: 4];
  end

  // blank_d travels with num so the enable matches the digit actually shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      idx     <= '0;
      idx_d   <= '0;
      blank_d <= 1'b0;
      started <= 1'b0;
      num     <= 4'd0;
      an      <= AN_ALL;
    end else begin
      if (presc == PW'(SCAN_DIV - 1)) begin
        presc <= '0;
        idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      num     <= digit_arr[idx];
      idx_d   <= idx;
      blank_d <= blank[idx];
      started <= 1'b1;
      an      <= (started && !blank_d) ? ~(EN_LSB << idx_d) : AN_ALL;
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner with LZB=1 and LZB=0 instances side by side.
module tb_display_scanner;

  localparam int DIGITS   = 4;
  localparam int WIDTH    = 14;
  localparam int SCAN_DIV = 4;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  typedef struct {
    logic [WIDTH-1:0] v;
    logic             ovf;
    logic [15:0]      bcd;
  } vec_t;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             load  = 1'b0;
  logic [WIDTH-1:0] value = '0;
  logic             busy1, ovf1, busy0, ovf0;
  logic [3:0]       num1, num0, an1, an0;

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;
  vec_t tbl [8];

  always #5 clk = ~clk;

  display_scanner #(.DIGITS(DIGITS), .WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV), .LZB(1)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .busy(busy1), .ovf(ovf1), .num(num1), .an(an1)
  );

  display_scanner #(.DIGITS(DIGITS), .WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV), .LZB(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .busy(busy0), .ovf(ovf0), .num(num0), .an(an0)
  );

  // Edges since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) t <= 0;
    else        t <= t + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_bcd(input int v);
    int dv;
    logic [15:0] r;
    dv = (v > 9999) ? 9999 : v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(dv % 10);
      dv = dv / 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] model_num(input logic [15:0] d, input int tt);
    int i;
    if (tt < 1) return 4'd0;
    i = ((tt - 1) / SCAN_DIV) % DIGITS;
    return 4'(d >> (4 * i));
  endfunction

  function automatic logic [3:0] model_an(input logic [15:0] d, input int tt, input bit lzb);
    int i;
    bit blanked;
    if (tt < 2) return 4'hF;
    i = ((tt - 2) / SCAN_DIV) % DIGITS;
    blanked = 1'b0;
    if (lzb && i > 0) begin
      blanked = 1'b1;
      for (int k = i; k < DIGITS; k++) if (4'(d >> (4 * k)) != 4'd0) blanked = 1'b0;
    end
    return blanked ? 4'hF : ~(4'b0001 << i);
  endfunction

  task automatic check_frame(input logic [15:0] d, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      check("num_lzb1", num1, model_num(d, t));
      check("an_lzb1",  an1,  model_an(d, t, 1'b1));
      check("num_lzb0", num0, model_num(d, t));
      check("an_lzb0",  an0,  model_an(d, t, 1'b0));
    end
  endtask

  // Caller is at a negedge; returns at the negedge after the accepting edge.
  task automatic start_load(input logic [WIDTH-1:0] v);
    value = v;
    load  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("busy_clears", busy1, 1'b0);
  endtask

  task automatic run_load(input logic [WIDTH-1:0] v, input logic exp_ovf, input logic [15:0] exp_bcd);
    int cnt;
    start_load(v);
    wait_idle(cnt);
    check("busy_cycles", cnt, WIDTH + 1);
    check("ovf_lzb1", ovf1, exp_ovf);
    check("ovf_lzb0", ovf0, exp_ovf);
    check("busy_match", busy0, busy1);
    repeat (2) @(negedge clk);
    check_frame(exp_bcd, 2 * FRAME);
  endtask

  initial begin
    int cnt;
    logic [WIDTH-1:0] rv;

    tbl[0] = '{14'd1234,  1'b0, 16'h1234};
    tbl[1] = '{14'd7,     1'b0, 16'h0007};
    tbl[2] = '{14'd12000, 1'b1, 16'h9999};
    tbl[3] = '{14'd5,     1'b0, 16'h0005};
    tbl[4] = '{14'd9999,  1'b0, 16'h9999};
    tbl[5] = '{14'd10000, 1'b1, 16'h9999};
    tbl[6] = '{14'd0,     1'b0, 16'h0000};
    tbl[7] = '{14'd16383, 1'b1, 16'h9999};

    repeat (3) @(negedge clk);
    check("rst_num",  num1,  4'd0);
    check("rst_an",   an1,   4'hF);
    check("rst_busy", busy1, 1'b0);
    check("rst_ovf",  ovf1,  1'b0);
    rst_n = 1'b1;
    check_frame(16'h0000, FRAME + 4);

    for (int i = 0; i < 8; i++) run_load(tbl[i].v, tbl[i].ovf, tbl[i].bcd);

    for (int i = 0; i < 6; i++) begin
      rv = WIDTH'($urandom_range(0, 16383));
      run_load(rv, (int'(rv) > 9999), model_bcd(int'(rv)));
    end

    // A load during conversion is dropped; one at E_WIDTH+2 is taken.
    start_load(14'd1234);
    repeat (2) @(negedge clk);
    value = 14'd42;
    load  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load  = 1'b0;
    wait_idle(cnt);
    check("busy_after_ignored", cnt, WIDTH + 1 - 3);
    start_load(14'd42);
    check("late_load_accepted", busy1, 1'b1);
    @(negedge clk);
    check_frame(16'h1234, 8);
    wait_idle(cnt);
    repeat (2) @(negedge clk);
    check_frame(16'h0042, FRAME);

    // Reset in the middle of a conversion aborts it without any commit.
    run_load(14'd1234, 1'b0, 16'h1234);
    start_load(14'd4321);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_num",  num1,  4'd0);
    check("abort_an",   an1,   4'hF);
    check("abort_busy", busy1, 1'b0);
    check("abort_ovf",  ovf1,  1'b0);
    check("abort_an0",  an0,   4'hF);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_frame(16'h0000, 3 * FRAME);
    check("post_rst_busy", busy1, 1'b0);
    check("post_rst_ovf",  ovf1,  1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
